des_cbc_ctrl: RTL
=================

# des_cbc_ctrl

CBC-mode block sequencer that sits in front of the iterative DES core and drives it. It accepts a stream of 64-bit blocks over a valid/ready handshake and chains each block with the IV or the previous ciphertext. It issues one block at a time to the core and returns the chained result over a second valid/ready handshake. It initiates every DES operation; the core only responds.

## Interface
- CNT_W, 16, width of the processed-block counter
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start_i  in  1  one-cycle pulse; latches key_i, iv_i and mode_i and opens a message
- mode_i  in  1  0 = encrypt, 1 = decrypt; passed to the core unchanged as its mode
- key_i  in  64  DES key
- iv_i  in  64  CBC initialisation vector
- in_valid  in  1  input block valid
- in_data  in  64  input block (plaintext when encrypting, ciphertext when decrypting)
- in_last  in  1  marks the final block of the message
- in_ready  out  1  input block accepted when in_valid && in_ready
- out_valid  out  1  output block valid
- out_data  out  64  chained result
- out_last  out  1  copy of in_last for this block
- out_ready  in  1  output accepted when out_valid && out_ready
- des_enable_o  out  1  run request to the core
- des_mode_o  out  1  latched mode
- des_key_o  out  64  latched key
- des_data_o  out  64  core input block
- des_data_i  in  64  core result
- des_ready_i  in  1  core result valid, sampled as a level
- busy_o  out  1  high whenever state is not IDLE
- blk_cnt_o  out  CNT_W  blocks delivered since the last start_i

## Operation
- Registers:
  - chain (64): the CBC chaining value.
  - csave (64): the saved input ciphertext.
  - key, mode.
  - last.
  - cnt.
  - out register holding out_data, out_valid and out_last.
- States: IDLE, ACCEPT, RUN, HOLD.
- IDLE:
  - in_ready = 0.
  - On start_i: key ← key_i, mode ← mode_i, chain ← iv_i, cnt ← 0; go to ACCEPT.
- ACCEPT:
  - in_ready = 1.
  - On in handshake:
    - des_data_o ← in_data ^ chain when encrypting; des_data_o ← in_data when decrypting.
    - csave ← in_data; last ← in_last; des_enable_o ← 1; go to RUN.
- RUN:
  - des_enable_o held at 1; des_data_o, des_key_o and des_mode_o held stable.
  - When des_ready_i = 1:
    - Encrypt: out_data ← des_data_i and chain ← des_data_i.
    - Decrypt: out_data ← des_data_i ^ chain and chain ← csave.
    - out_valid ← 1, out_last ← last, des_enable_o ← 0; go to HOLD.
- HOLD:
  - On out handshake: out_valid ← 0 and cnt ← cnt + 1, wrapping modulo 2^CNT_W.
  - Leave HOLD only when des_ready_i = 0 and out_valid = 0 (the core has released and the result is consumed). Go to IDLE if last = 1, otherwise to ACCEPT.
- Ignored inputs:
  - start_i outside IDLE is ignored; the latched key, IV and mode do not change mid-message.
  - des_ready_i outside RUN is ignored.
  - in_valid outside ACCEPT is not acknowledged.

## Timing
- All outputs are registered.
- Reset values: in_ready = 0, out_valid = 0, out_last = 0, out_data = 0, des_enable_o = 0, des_data_o = 0, des_key_o = 0, des_mode_o = 0, busy_o = 0, blk_cnt_o = 0. Internal state: chain = 0, state = IDLE.
- start_i at cycle T: busy_o = 1 and in_ready = 1 at T+1.
- Input handshake at cycle T: des_enable_o = 1 at T+1.
- des_ready_i first seen high at cycle R: out_valid = 1 and des_enable_o = 0 at R+1.
- Handshake at cycle H with des_ready_i already low: in_ready = 1 at H+1, or busy_o = 0 at H+1 when the block was the last one.
- Latency per block = core latency + 3 cycles of overhead when out_ready is held high. Blocks are strictly serial, one in flight.
- out_ready low: out_valid, out_data and out_last stay stable; in_ready = 0 and des_enable_o = 0 for the whole stall.
- Reset asserted in any state: the state machine returns to IDLE and the in-flight block is discarded. At the next edge des_enable_o = 0 and out_valid = 0. The core shares the same reset.

## Test plan
- Reset: hold reset 3 cycles mid-traffic -> all outputs equal their reset values, busy_o = 0.
- Single-block encrypt: iv = 0, key = 133457799BBCDFF1, in_data = 0123456789ABCDEF, in_last = 1 -> out_data = 85E813540F0AB405, out_last = 1, blk_cnt_o = 1, then IDLE.
- Two-block encrypt chaining: iv = 0, blocks 0123456789ABCDEF then 84CB563386A179EA -> both outputs = 85E813540F0AB405 (the second core input equals 0123456789ABCDEF).
- Two-block decrypt: iv = 0, feed both 85E813540F0AB405 blocks -> outputs 0123456789ABCDEF then 84CB563386A179EA.
- Backpressure and ignored start: out_ready = 0 for 20 cycles with start_i pulsed mid-stall -> out_data stable, in_ready = 0, des_enable_o = 0, latched key and mode unchanged; output delivered on release.
- Reset during RUN: des_enable_o = 0 and out_valid = 0 on the next cycle. A fresh single-block encrypt afterwards still yields 85E813540F0AB405.

Source files
------------

// File: rtl/des_cbc_ctrl.sv
// CBC chaining sequencer in front of an iterative DES core: accepts 64-bit blocks,
// runs them through the core one at a time and returns the chained result.
module des_cbc_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic [63:0]      key_i,
  input  logic [63:0]      iv_i,
  input  logic             in_valid,
  input  logic [63:0]      in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  output logic [63:0]      out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             des_enable_o,
  output logic             des_mode_o,
  output logic [63:0]      des_key_o,
  output logic [63:0]      des_data_o,
  input  logic [63:0]      des_data_i,
  input  logic             des_ready_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] blk_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCEPT = 2'd1,
    S_RUN    = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [63:0]      key_q, key_d;
  logic             mode_q, mode_d;
  logic [63:0]      chain_q, chain_d;
  logic [63:0]      csave_q, csave_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic             des_en_q, des_en_d;
  logic [63:0]      des_data_q, des_data_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;

  logic in_hs;
  logic out_hs;
  logic out_done;

  assign in_hs    = in_valid && in_ready_q;
  assign out_hs   = out_valid_q && out_ready;
  // Result counts as consumed in the cycle of its handshake, so HOLD can exit without a bubble.
  assign out_done = !out_valid_q || out_hs;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      key_q       <= '0;
      mode_q      <= 1'b0;
      chain_q     <= '0;
      csave_q     <= '0;
      last_q      <= 1'b0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      des_en_q    <= 1'b0;
      des_data_q  <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      mode_q      <= mode_d;
      chain_q     <= chain_d;
      csave_q     <= csave_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      des_en_q    <= des_en_d;
      des_data_q  <= des_data_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_i) state_d = S_ACCEPT;
      S_ACCEPT: if (in_hs) state_d = S_RUN;
      S_RUN:    if (des_ready_i) state_d = S_HOLD;
      S_HOLD: begin
        if (!des_ready_i && out_done) state_d = last_q ? S_IDLE : S_ACCEPT;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    key_d       = key_q;
    mode_d      = mode_q;
    chain_d     = chain_q;
    csave_d     = csave_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    des_en_d    = des_en_q;
    des_data_d  = des_data_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          key_d   = key_i;
          mode_d  = mode_i;
          chain_d = iv_i;
          cnt_d   = '0;
        end
      end
      S_ACCEPT: begin
        if (in_hs) begin
          des_data_d = mode_q ? in_data : (in_data ^ chain_q);
          csave_d    = in_data;
          last_d     = in_last;
          des_en_d   = 1'b1;
        end
      end
      S_RUN: begin
        if (des_ready_i) begin
          // Decrypt chains on the saved ciphertext, encrypt on the fresh core output.
          out_data_d  = mode_q ? (des_data_i ^ chain_q) : des_data_i;
          chain_d     = mode_q ? csave_q : des_data_i;
          out_valid_d = 1'b1;
          out_last_d  = last_q;
          des_en_d    = 1'b0;
        end
      end
      S_HOLD: begin
        if (out_hs) begin
          out_valid_d = 1'b0;
          cnt_d       = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
    in_ready_d = (state_d == S_ACCEPT);
    busy_d     = (state_d != S_IDLE);
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_last     = out_last_q;
  assign des_enable_o = des_en_q;
  assign des_mode_o   = mode_q;
  assign des_key_o    = key_q;
  assign des_data_o   = des_data_q;
  assign busy_o       = busy_q;
  assign blk_cnt_o    = cnt_q;

endmodule
